// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: update opcodes, FSM states and
// the default reset vector. Imported by the controller and by the bench.
package pc_sequencer_pkg;

  // Update opcode encodings carried on upd_op
  localparam logic [1:0] OP_INC    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_JUMP   = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // Default PC value after reset
  localparam logic [7:0] DEFAULT_RESET_VECTOR = 8'h00;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_CALC   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

endpackage

// File: rtl/pc_adder.sv
// Purely combinational WIDTH-bit adder with carry-in. The carry-out is
// dropped so the sum wraps modulo 2^WIDTH.
module pc_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum
);

  logic [WIDTH-1:0] w_cin_ext;

  // Zero-extend the carry-in so every operand has the same width
  assign w_cin_ext = {{(WIDTH-1){1'b0}}, i_cin};

  // Modulo-2^WIDTH sum; no overflow flag
  assign o_sum = i_a + i_b + w_cin_ext;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. A five-state FSM requests a fetch, waits for
// the instruction, computes the next PC through pc_adder and commits it.
// Handshake: fetch_req is a one-cycle request for address pc; the fetched
// instruction is accepted in the first WAIT cycle that has instr_valid=1
// (no back-pressure toward the fetch side); upd_done pulses for one cycle
// while pc already holds the newly committed value. hold freezes every
// register and masks both pulses until it falls.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             hold,
  input  logic             instr_valid,
  input  logic [1:0]       upd_op,
  input  logic             take,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_req,
  output logic             upd_done,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_sum_q;
  logic [1:0]       r_op;
  logic             r_take;
  logic [WIDTH-1:0] r_offset;
  logic [WIDTH-1:0] r_target;
  logic             r_fetch_req;
  logic             r_upd_done;

  logic [WIDTH-1:0] w_add_b;
  logic [WIDTH-1:0] w_sum;

  // Only a taken branch adds the offset; everything else adds zero (+1 via Cin)
  assign w_add_b = (r_op == OP_BRANCH && r_take) ? r_offset : '0;

  pc_adder #(.WIDTH(WIDTH)) u_pc_adder (
    .i_a   (r_pc),
    .i_b   (w_add_b),
    .i_cin (1'b1),
    .o_sum (w_sum)
  );

  // Sequencer FSM: owns all state; hold freezes everything in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VECTOR;
      r_sum_q     <= '0;
      r_op        <= '0;
      r_take      <= 1'b0;
      r_offset    <= '0;
      r_target    <= '0;
      r_fetch_req <= 1'b0;
      r_upd_done  <= 1'b0;
    end else if (!hold) begin
      r_fetch_req <= 1'b0;
      r_upd_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (instr_valid) begin
            r_op     <= upd_op;
            r_take   <= take;
            r_offset <= offset;
            r_target <= target;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_sum_q <= (r_op == OP_JUMP) ? r_target : w_sum;
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_pc       <= r_sum_q;
          r_upd_done <= 1'b1;
          if (run) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc        = r_pc;
  assign fetch_req = r_fetch_req & ~hold;
  assign upd_done  = r_upd_done & ~hold;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic       clk;
  logic       rst;
  logic       run;
  logic       hold;
  logic       instr_valid;
  logic [1:0] upd_op;
  logic       take;
  logic [7:0] offset;
  logic [7:0] target;
  logic [7:0] pc;
  logic       fetch_req;
  logic       upd_done;
  logic       busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .hold        (hold),
    .instr_valid (instr_valid),
    .upd_op      (upd_op),
    .take        (take),
    .offset      (offset),
    .target      (target),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .upd_done    (upd_done),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Starting in a FETCH cycle: verify the fetch, deliver one instruction in
  // the first WAIT cycle (t), then expect upd_done with the new pc at t+3.
  task automatic do_instr(input string tag, input logic [1:0] op, input logic tk,
                          input logic [7:0] off, input logic [7:0] tgt,
                          input logic [7:0] fetch_pc, input logic [7:0] exp_pc);
    check({tag, "_fetch_req"}, 32'(fetch_req), 32'd1);
    check({tag, "_fetch_pc"}, 32'(pc), 32'(fetch_pc));
    tick();                       // WAIT, cycle t
    upd_op = op; take = tk; offset = off; target = tgt; instr_valid = 1'b1;
    tick();                       // CALC, t+1
    instr_valid = 1'b0;
    check({tag, "_no_done_calc"}, 32'(upd_done), 32'd0);
    tick();                       // COMMIT, t+2
    check({tag, "_no_done_commit"}, 32'(upd_done), 32'd0);
    check({tag, "_pc_before"}, 32'(pc), 32'(fetch_pc));
    tick();                       // t+3
    check({tag, "_upd_done"}, 32'(upd_done), 32'd1);
    check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; hold = 1'b0; instr_valid = 1'b0;
    upd_op = OP_INC; take = 1'b0; offset = 8'h00; target = 8'h00;
    #1;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fetch", 32'(fetch_req), 32'd0);
    check("rst_done", 32'(upd_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_stays", 32'(dbg_state), 32'(S_IDLE));
    check("idle_busy", 32'(busy), 32'd0);

    // Start sequencing and run three increments
    run = 1'b1;
    tick();
    check("first_fetch_busy", 32'(busy), 32'd1);
    do_instr("inc1", OP_INC, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01);
    do_instr("inc2", OP_INC, 1'b0, 8'h00, 8'h00, 8'h01, 8'h02);
    do_instr("inc3", OP_INC, 1'b0, 8'h00, 8'h00, 8'h02, 8'h03);

    // Wrap-around: increment and taken branch from FF
    do_instr("jmp_ff_a", OP_JUMP, 1'b0, 8'h00, 8'hFF, 8'h03, 8'hFF);
    do_instr("inc_wrap", OP_INC, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00);
    do_instr("jmp_ff_b", OP_JUMP, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF);
    do_instr("br_wrap", OP_BRANCH, 1'b1, 8'h02, 8'h00, 8'hFF, 8'h02);

    // Negative offset, taken and not taken
    do_instr("jmp_01_a", OP_JUMP, 1'b0, 8'h00, 8'h01, 8'h02, 8'h01);
    do_instr("br_neg_t", OP_BRANCH, 1'b1, 8'hFC, 8'h00, 8'h01, 8'hFE);
    do_instr("jmp_01_b", OP_JUMP, 1'b0, 8'h00, 8'h01, 8'hFE, 8'h01);
    do_instr("br_neg_nt", OP_BRANCH, 1'b0, 8'hFC, 8'h00, 8'h01, 8'h02);

    // Jump ignores offset/take; reserved op behaves as increment
    do_instr("jmp_a5", OP_JUMP, 1'b1, 8'h7F, 8'hA5, 8'h02, 8'hA5);
    do_instr("jmp_10", OP_JUMP, 1'b0, 8'h00, 8'h10, 8'hA5, 8'h10);
    do_instr("rsvd", OP_RSVD, 1'b1, 8'h50, 8'h77, 8'h10, 8'h11);

    // hold outranks instr_valid in WAIT
    check("hw_fetch", 32'(fetch_req), 32'd1);
    tick();                                   // WAIT
    hold = 1'b1; instr_valid = 1'b1; upd_op = OP_JUMP; target = 8'h33;
    tick();
    check("hw_state", 32'(dbg_state), 32'(S_WAIT));
    hold = 1'b0; instr_valid = 1'b0;
    tick();
    check("hw_still_wait", 32'(dbg_state), 32'(S_WAIT));

    // Now accept an increment and hold for 4 cycles in CALC
    upd_op = OP_INC; take = 1'b0; instr_valid = 1'b1;
    tick();                                   // CALC
    instr_valid = 1'b0;
    hold = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("hc_no_done", 32'(upd_done), 32'd0);
      check("hc_pc", 32'(pc), 32'h11);
      tick();
    end
    check("hc_state", 32'(dbg_state), 32'(S_CALC));
    check("hc_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    tick();                                   // COMMIT
    check("hc_commit_no_done", 32'(upd_done), 32'd0);
    tick();
    check("hc_done", 32'(upd_done), 32'd1);
    check("hc_pc_new", 32'(pc), 32'h12);

    // run drops during CALC: update still completes, then IDLE
    do_instr("rd_setup", OP_INC, 1'b0, 8'h00, 8'h00, 8'h12, 8'h13);
    tick();                                   // WAIT
    upd_op = OP_INC; instr_valid = 1'b1;
    tick();                                   // CALC
    instr_valid = 1'b0; run = 1'b0;
    tick();                                   // COMMIT
    tick();
    check("rd_done", 32'(upd_done), 32'd1);
    check("rd_pc", 32'(pc), 32'h14);
    check("rd_no_fetch", 32'(fetch_req), 32'd0);
    check("rd_idle", 32'(dbg_state), 32'(S_IDLE));
    check("rd_busy", 32'(busy), 32'd0);
    tick();
    check("rd_done_once", 32'(upd_done), 32'd0);

    // Reset in COMMIT with sum_q=40 discards the update
    run = 1'b1;
    tick();                                   // FETCH
    tick();                                   // WAIT
    upd_op = OP_JUMP; target = 8'h40; instr_valid = 1'b1;
    tick();                                   // CALC
    instr_valid = 1'b0;
    tick();                                   // COMMIT
    check("rc_in_commit", 32'(dbg_state), 32'(S_COMMIT));
    rst = 1'b1;
    #1;
    check("rc_pc_now", 32'(pc), 32'h00);
    check("rc_busy", 32'(busy), 32'd0);
    check("rc_done", 32'(upd_done), 32'd0);
    tick();
    check("rc_done_after", 32'(upd_done), 32'd0);
    check("rc_pc_after", 32'(pc), 32'h00);
    rst = 1'b0;
    tick();                                   // FETCH
    check("rc_refetch", 32'(dbg_state), 32'(S_FETCH));
    check("rc_refetch_req", 32'(fetch_req), 32'd1);
    check("rc_refetch_pc", 32'(pc), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters: WIDTH, 8, PC datapath width; RESET_VECTOR, 8'h00, PC value after reset.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 run  input  1  level; enables instruction sequencing.
REQ-005 hold  input  1  level; freezes FSM and all registers when high.
REQ-006 instr_valid  input  1  fetched instruction available; operands below valid this cycle.
REQ-007 upd_op  input  2  00 increment, 01 conditional branch, 10 jump, 11 reserved.
REQ-008 take  input  1  branch condition; sampled only with upd_op=01.
REQ-009 offset  input  WIDTH  signed two's-complement branch offset.
REQ-010 target  input  WIDTH  absolute jump target.
REQ-011 pc  output  WIDTH  current program counter (registered).
REQ-012 fetch_req  output  1  one-cycle request to fetch from address pc.
REQ-013 upd_done  output  1  one-cycle pulse; pc holds the newly committed value this cycle.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, WAIT, CALC and COMMIT.
REQ-016 IDLE SHALL go to FETCH when run=1; otherwise it SHALL stay in IDLE.
REQ-017 FETCH SHALL assert fetch_req for exactly one cycle and then go to WAIT.
REQ-018 WAIT SHALL stay in WAIT until instr_valid=1.
REQ-019 In the WAIT cycle with instr_valid=1, the block SHALL capture upd_op, take, offset and target into registers and go to CALC; instr_valid SHALL be ignored in all other states.
REQ-020 CALC SHALL compute the adder operands and register the result in sum_q, then go to COMMIT.
  - increment, branch not-taken, or reserved op: A=pc, B=0, Cin=1
  - branch taken: A=pc, B=offset, Cin=1
  - jump: sum_q=target, adder bypassed
REQ-021 Addition SHALL be modulo 2^WIDTH; carry-out SHALL be discarded; no overflow flag is produced.
REQ-022 At the clock edge leaving COMMIT, the block SHALL load pc<=sum_q and set upd_done=1 for the following cycle only.
REQ-023 COMMIT SHALL go to FETCH if run=1, else to IDLE; a run deassert SHALL never abort an update already in progress.
REQ-024 Latency: instr_valid accepted at cycle t gives upd_done=1 with the new pc at cycle t+3, and fetch_req at t+3 if run=1.
REQ-025 With hold=1, state, pc, sum_q and captured operands SHALL be frozen, and fetch_req and upd_done SHALL be forced to 0; the pending pulse SHALL be emitted in the first cycle after hold falls.
REQ-026 hold SHALL take priority over run and instr_valid arriving in the same cycle.

Reset
REQ-027 rst=1 SHALL immediately force: state=IDLE, pc=RESET_VECTOR, sum_q=0, captured operands=0, fetch_req=0, upd_done=0, busy=0.
REQ-028 A reset in any state, including mid-CALC or mid-COMMIT, SHALL discard the pending update; pc SHALL NOT take sum_q.
REQ-029 After rst falls, the first FETCH SHALL present pc=RESET_VECTOR.

Structure
REQ-030 The upd_op encodings, FSM state encodings and the default RESET_VECTOR SHALL live in a shared package/header used by the controller and by the bench.
REQ-031 The adder SHALL be a separate sub-module, pc_adder: WIDTH-bit A, B, Cin in, Sum out, purely combinational, instantiated once.
REQ-032 The controller SHALL own all registers; pc_adder SHALL contain no state.

Verification
REQ-033 Reset then run=1, increment ops from pc=00 -> fetch_req at pc=00, upd_done with pc=01, 02, 03, with 3-cycle accept-to-done latency each time.
REQ-034 Wrap: pc=FF, increment -> pc=00; pc=FF, branch take=1, offset=02 -> pc=02.
REQ-035 Negative branch: pc=01, offset=FC, take=1 -> pc=FE; the same with take=0 -> pc=02.
REQ-036 Jump: target=A5 -> pc=A5 regardless of offset/take; reserved op 11 at pc=10 -> pc=11.
REQ-037 hold=1 for 4 cycles during CALC -> no upd_done and pc unchanged; the result commits 1 cycle after hold falls; run=0 during CALC -> commit completes, then IDLE with busy=0.
REQ-038 rst asserted in COMMIT with sum_q=40 -> pc=00 immediately, no upd_done; after release the first fetch_req is at pc=00.
